button_conditioner: RTL and testbench

//  Upstream input stage for the VGA game logic. Synchronises, debounces and edge-detects
//  the five push buttons (btnU, btnD, btnL, btnR, btnC) in the board_clk domain.

---
 rtl/btn_cond_pkg.sv | 21 ++
 rtl/btn_debounce_fsm.sv | 159 +++++++++++++++
 rtl/button_conditioner.sv | 56 +++++
 tb/tb_button_conditioner.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_cond_pkg.sv
// Shared definitions for the button conditioner: FSM state encodings,
// button index constants and counter widths.
package btn_cond_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_ARM_PRESS   = 2'd1,
    ST_PRESSED     = 2'd2,
    ST_ARM_RELEASE = 2'd3
  } btn_state_e;

  localparam int unsigned BTN_U = 0;
  localparam int unsigned BTN_D = 1;
  localparam int unsigned BTN_L = 2;
  localparam int unsigned BTN_R = 3;
  localparam int unsigned BTN_C = 4;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned RPT_W = 8;

endpackage

// File: rtl/btn_debounce_fsm.sv
// One button: 2-FF synchroniser, tick-driven debounce FSM and registered
// level / press / release outputs. Optional auto-repeat under BTN_AUTOREPEAT_EN.
module btn_debounce_fsm
  import btn_cond_pkg::*;
#(
  parameter int unsigned STABLE_CNT  = 4
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DLY  = 64,
  parameter int unsigned REPEAT_RATE = 16
`endif
) (
  input  logic board_clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [CNT_W-1:0] STABLE_V = CNT_W'(STABLE_CNT);

  logic             sync_q1;
  logic             synced;
  btn_state_e       state;
  btn_state_e       state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             level_d;
  logic             press_d;
  logic             release_d;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [RPT_W-1:0] REPEAT_DLY_V  = RPT_W'(REPEAT_DLY);
  localparam logic [RPT_W-1:0] REPEAT_RATE_V = RPT_W'(REPEAT_RATE);

  logic [RPT_W-1:0] rpt;
  logic [RPT_W-1:0] rpt_d;
  logic [RPT_W-1:0] rpt_inc;
`endif

  // Two-flop synchroniser for the asynchronous pin
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      synced  <= 1'b0;
    end else begin
      sync_q1 <= raw;
      synced  <= sync_q1;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rpt           <= '0;
`endif
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      level         <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
`ifdef BTN_AUTOREPEAT_EN
      rpt           <= rpt_d;
`endif
    end
  end

  // Next-state, stable counter and pulse generation; advances on ticks only
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    press_d   = 1'b0;
    release_d = 1'b0;
    cnt_inc   = cnt + CNT_W'(1);

    if (tick) begin
      unique case (state)
        ST_IDLE: begin
          if (synced) begin
            if (STABLE_CNT == 1) begin
              state_d = ST_PRESSED;
              cnt_d   = '0;
              press_d = 1'b1;
            end else begin
              state_d = ST_ARM_PRESS;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_ARM_PRESS: begin
          if (!synced) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_inc == STABLE_V) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_PRESSED: begin
          if (!synced) begin
            if (STABLE_CNT == 1) begin
              state_d   = ST_IDLE;
              cnt_d     = '0;
              release_d = 1'b1;
            end else begin
              state_d = ST_ARM_RELEASE;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_ARM_RELEASE: begin
          if (synced) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end else if (cnt_inc == STABLE_V) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    // Repeat counter runs only on held ticks in PRESSED; ARM_RELEASE freezes it
    rpt_d   = rpt;
    rpt_inc = rpt + RPT_W'(1);
    if (tick && (state == ST_PRESSED) && synced) begin
      if (rpt_inc == REPEAT_DLY_V) begin
        press_d = 1'b1;
        rpt_d   = REPEAT_DLY_V - REPEAT_RATE_V;
      end else begin
        rpt_d = rpt_inc;
      end
    end
    if ((state_d == ST_IDLE) || (state_d == ST_ARM_PRESS)) begin
      rpt_d = '0;
    end
`endif

    level_d = (state_d == ST_PRESSED) || (state_d == ST_ARM_RELEASE);
  end

endmodule

// File: rtl/button_conditioner.sv
// Button input stage: shared sample prescaler plus one debounce FSM per button.
// Optional auto-repeat of btn_press is enabled by defining BTN_AUTOREPEAT_EN.
module button_conditioner
  import btn_cond_pkg::*;
#(
  parameter int unsigned N_BTN       = 5,
  parameter int unsigned SAMPLE_DIV  = 18,
  parameter int unsigned STABLE_CNT  = 4
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DLY  = 64,
  parameter int unsigned REPEAT_RATE = 16
`endif
) (
  input  logic             board_clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             sample_tick
);

  logic [SAMPLE_DIV-1:0] presc;

  // Free-running prescaler; tick is registered one cycle after all-ones
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      presc       <= '0;
      sample_tick <= 1'b0;
    end else begin
      presc       <= presc + SAMPLE_DIV'(1);
      sample_tick <= (presc == '1);
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce_fsm #(
      .STABLE_CNT (STABLE_CNT)
`ifdef BTN_AUTOREPEAT_EN
      ,
      .REPEAT_DLY (REPEAT_DLY),
      .REPEAT_RATE(REPEAT_RATE)
`endif
    ) u_fsm (
      .board_clk    (board_clk),
      .reset        (reset),
      .tick         (sample_tick),
      .raw          (btn_raw[i]),
      .level        (btn_level[i]),
      .press_pulse  (btn_press[i]),
      .release_pulse(btn_release[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: tick-aligned stimulus table, scoreboard of
// expected outputs due at a given tick, plus reset and auto-repeat sequences.
module tb_button_conditioner;
  import btn_cond_pkg::*;

  localparam int unsigned N = 5;

  logic         board_clk = 1'b0;
  logic         reset     = 1'b1;
  logic [N-1:0] btn_raw   = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic         sample_tick;

  button_conditioner #(
    .N_BTN      (N),
    .SAMPLE_DIV (2),
    .STABLE_CNT (3)
`ifdef BTN_AUTOREPEAT_EN
    ,
    .REPEAT_DLY (8),
    .REPEAT_RATE(4)
`endif
  ) dut (
    .board_clk  (board_clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .sample_tick(sample_tick)
  );

  always #5 board_clk = ~board_clk;

  typedef struct packed {
    logic         rst_before;
    logic [N-1:0] raw;
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
  } step_t;

  typedef struct packed {
    int           due;
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
  } exp_t;

  step_t stim[$];
  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;

  // Reference prescaler: tick every 4 cycles, tick_idx counts tick edges
  logic [1:0] m_cnt;
  logic       m_tick;
  int         tick_idx = 0;

  always @(posedge board_clk or posedge reset) begin
    if (reset) begin
      m_cnt  <= 2'd0;
      m_tick <= 1'b0;
    end else begin
      m_cnt  <= m_cnt + 2'd1;
      m_tick <= (m_cnt == 2'd3);
      if (m_tick) tick_idx <= tick_idx + 1;
    end
  end

  function automatic void add(input logic r, input logic [N-1:0] raw,
                              input logic [N-1:0] level, input logic [N-1:0] press,
                              input logic [N-1:0] rel);
    stim.push_back(step_t'{rst_before: r, raw: raw, level: level, press: press, rel: rel});
  endfunction

  // One cycle: compare tick, pop due expectations, otherwise require no pulses
  task automatic cycle();
    exp_t e;
    @(negedge board_clk);
    if (!reset) begin
      checks++;
      if (sample_tick !== m_tick) begin
        errors++;
        $display("FAIL sample_tick tick %0d: got %b want %b", tick_idx, sample_tick, m_tick);
      end
      if (sb.size() > 0 && sb[0].due == tick_idx) begin
        e = sb.pop_front();
        checks++;
        if (btn_level !== e.level || btn_press !== e.press || btn_release !== e.rel) begin
          errors++;
          $display("FAIL step tick %0d: got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=%b",
                   tick_idx, btn_level, btn_press, btn_release, e.level, e.press, e.rel);
        end
      end else begin
        checks++;
        if (btn_press !== '0 || btn_release !== '0) begin
          errors++;
          $display("FAIL stray_pulse tick %0d: got prs=%b rel=%b want 0",
                   tick_idx, btn_press, btn_release);
        end
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 40) begin
      cycle();
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({btn_level, btn_press, btn_release, sample_tick} !== '0) begin
      errors++;
      $display("FAIL %s: got lvl=%b prs=%b rel=%b tick=%b want all 0",
               name, btn_level, btn_press, btn_release, sample_tick);
    end
  endtask

  // One-cycle asynchronous reset pulse mid-operation
  task automatic do_reset();
    drain();
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    @(negedge board_clk);
    reset = 1'b0;
    sb.delete();
  endtask

  // Drive one sample period: raw changes just before a tick edge and is seen one tick later
  task automatic apply(input step_t s);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!m_tick && n < 16);
    if (!m_tick) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: got no tick in %0d cycles want tick", n);
    end
    btn_raw = s.raw;
    sb.push_back(exp_t'{due: tick_idx + 2, level: s.level, press: s.press, rel: s.rel});
  endtask

  initial begin
    logic [N-1:0] u;
    logic [N-1:0] c;
    logic [N-1:0] z;
    logic         ar;
    u  = N'(1) << BTN_U;
    c  = N'(1) << BTN_C;
    z  = '0;
`ifdef BTN_AUTOREPEAT_EN
    ar = 1'b1;
`else
    ar = 1'b0;
`endif

    // Clean press on bit 0, then release
    add(0, u, z, z, z);  add(0, u, z, z, z);  add(0, u, u, u, z);  add(0, u, u, z, z);
    add(0, z, u, z, z);  add(0, z, u, z, z);  add(0, z, z, z, u);
    // Press again, 2-sample low blip (no release), then real release
    add(0, u, z, z, z);  add(0, u, z, z, z);  add(0, u, u, u, z);
    add(0, z, u, z, z);  add(0, z, u, z, z);  add(0, u, u, z, z);  add(0, u, u, z, z);
    add(0, z, u, z, z);  add(0, z, u, z, z);  add(0, z, z, z, u);
    // Bounce on bit 1: 1,0,1,1,0 then steady 1
    add(0, 5'b00010, z, z, z);  add(0, z, z, z, z);
    add(0, 5'b00010, z, z, z);  add(0, 5'b00010, z, z, z);  add(0, z, z, z, z);
    add(0, 5'b00010, z, z, z);  add(0, 5'b00010, z, z, z);
    add(0, 5'b00010, 5'b00010, 5'b00010, z);
    add(0, z, 5'b00010, z, z);  add(0, z, 5'b00010, z, z);  add(0, z, z, z, 5'b00010);
    // All five buttons together
    add(0, '1, z, z, z);  add(0, '1, z, z, z);  add(0, '1, '1, '1, z);  add(0, '1, '1, z, z);
    add(0, z, '1, z, z);  add(0, z, '1, z, z);  add(0, z, z, z, '1);
    // Bit 0 pressed, bit 2 two samples into ARM_PRESS, then reset
    add(0, u, z, z, z);  add(0, u, z, z, z);  add(0, u, u, u, z);  add(0, u, u, z, z);
    add(0, 5'b00101, u, z, z);  add(0, 5'b00101, u, z, z);
    // After reset both buttons must re-qualify from scratch
    add(1, 5'b00101, z, z, z);
    add(0, 5'b00101, 5'b00101, 5'b00101, z);  add(0, 5'b00101, 5'b00101, z, z);
    add(0, z, 5'b00101, z, z);  add(0, z, 5'b00101, z, z);  add(0, z, z, z, 5'b00101);
    // Bit 4 held 20 samples: press at 3, repeats at 11, 15, 19 when enabled
    for (int n = 1; n <= 20; n++) begin
      add(0, c, (n >= 3) ? c : z,
          ((n == 3) || (ar && n >= 11 && ((n - 11) % 4) == 0)) ? c : z, z);
    end
    add(0, z, c, z, z);  add(0, z, c, z, z);  add(0, z, z, z, c);

    repeat (2) @(negedge board_clk);
    check_zero("reset_state");
    reset = 1'b0;

    foreach (stim[i]) begin
      if (stim[i].rst_before) do_reset();
      apply(stim[i]);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
